// File: rtl/stream_deinterleave.sv
// Channel-interleaved sample stream to parallel frame vector, double-buffered (assembly + output).
// Optional STREAM_DEINTERLEAVE_FRAME_CNT_EN adds frame_cnt / drop_cnt status counters.
module stream_deinterleave #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_STREAMS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_first,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] out_data [0:NUM_STREAMS-1],
    output logic                  out_valid,
    input  logic                  out_ready,
`ifdef STREAM_DEINTERLEAVE_FRAME_CNT_EN
    output logic [31:0]           frame_cnt,
    output logic [15:0]           drop_cnt,
`endif
    output logic                  sync_err
);

    localparam int CW = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_STREAMS - 1);

    typedef enum logic {COLLECT, PENDING} state_t;

    state_t                state;
    logic [CW-1:0]         ch_idx;
    logic [DATA_WIDTH-1:0] asm_buf    [0:NUM_STREAMS-1];
    logic [DATA_WIDTH-1:0] frame_next [0:NUM_STREAMS-1];

    logic accept;
    logic slot_free;
    logic resync;
    logic last_beat;
    logic load_direct;
    logic load_pending;

    always_comb begin
        accept       = s_valid && s_ready;
        slot_free    = !out_valid || out_ready;
        resync       = accept && s_first && (ch_idx != '0);
        last_beat    = accept && !resync && (ch_idx == LAST_IDX);
        load_direct  = (state == COLLECT) && last_beat && slot_free;
        load_pending = (state == PENDING) && slot_free;
    end

    // Completed frame as it will look once the final beat lands in the assembly buffer.
    always_comb begin
        frame_next         = asm_buf;
        frame_next[ch_idx] = s_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= COLLECT;
            s_ready   <= 1'b1;
            ch_idx    <= '0;
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
            for (int unsigned i = 0; i < NUM_STREAMS; i++) begin
                asm_buf[i]  <= '0;
                out_data[i] <= '0;
            end
        end else begin
            sync_err <= 1'b0;
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            case (state)
                COLLECT: begin
                    if (accept) begin
                        if (resync) begin
                            asm_buf[0] <= s_data;
                            ch_idx     <= CW'(1);
                            sync_err   <= 1'b1;
                        end else begin
                            asm_buf[ch_idx] <= s_data;
                            if (ch_idx == LAST_IDX) begin
                                ch_idx <= '0;
                                if (slot_free) begin
                                    out_data  <= frame_next;
                                    out_valid <= 1'b1;
                                end else begin
                                    state   <= PENDING;
                                    s_ready <= 1'b0;
                                end
                            end else begin
                                ch_idx <= ch_idx + 1'b1;
                            end
                        end
                    end
                end
                PENDING: begin
                    if (slot_free) begin
                        out_data  <= asm_buf;
                        out_valid <= 1'b1;
                        state     <= COLLECT;
                        s_ready   <= 1'b1;
                    end
                end
                default: begin
                    state   <= COLLECT;
                    s_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef STREAM_DEINTERLEAVE_FRAME_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (load_direct || load_pending)
                frame_cnt <= frame_cnt + 32'd1;
            if (resync && (drop_cnt != 16'hFFFF))
                drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule
